// File: rtl/qsys_tgen_pkg.sv
// Shared types, widths and the data-pattern helper for the Qsys master traffic generator.
// Contents:
//   tgen_state_t  - run state machine encoding
//   ERR_CNT_W     - width of the mismatch counter
//   PERF_CNT_W    - width of the optional performance counters
//   tgen_pattern  - {src, snk, idx} word for a given index, MSB-aligned to the data width
package qsys_tgen_pkg;

  localparam int unsigned ERR_CNT_W  = 16;
  localparam int unsigned PERF_CNT_W = 32;
  localparam int unsigned PAT_MAX_W  = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StDrain,
    StDone
  } tgen_state_t;

  // Result is right-aligned in PAT_MAX_W bits; callers keep the low 'width' bits.
  function automatic logic [PAT_MAX_W-1:0] tgen_pattern(input logic [7:0]  src,
                                                        input logic [7:0]  snk,
                                                        input logic [31:0] idx,
                                                        input int unsigned width);
    logic [PAT_MAX_W-1:0] idx_mask;
    idx_mask = (64'd1 << (width - 16)) - 64'd1;
    return ({56'd0, src} << (width - 8)) | ({56'd0, snk} << (width - 16)) |
           ({32'd0, idx} & idx_mask);
  endfunction

endpackage

// File: rtl/qsys_tgen_ts_fifo.sv
// In-order FIFO of read-issue timestamps used for read latency accounting.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   clr_i        - synchronous flush (new run)
//   push_i       - store data_i (one per accepted read)
//   pop_i        - drop the head entry (one per answered read)
//   head_o       - oldest stored timestamp
// The owner guarantees no push when full and no pop when empty.
module qsys_tgen_ts_fifo
  import qsys_tgen_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = PERF_CNT_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/qsys_master_tgen.sv
// Avalon-MM master traffic generator: writes NUM_REQ tagged words to addresses 0..NUM_REQ-1,
// reads them back with at most MAX_OUTSTANDING reads in flight and checks the in-order
// responses against the same pattern.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start                    - run request pulse (honoured in idle/done only)
//   done, error, err_count   - run complete, sticky error, saturating error count
//   writedata, address       - request payload (word address)
//   write, read              - request strobes, never both high
//   waitrequest              - slave stall
//   readdata, readdatavalid  - in-order read responses
// Optional (QSYS_TGEN_PERF_EN defined):
//   run_cycles               - cycles from the one after start to done rising, saturating
//   lat_sum                  - sum of read accept-to-response latencies, saturating
module qsys_master_tgen
  import qsys_tgen_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned ADDR_WIDTH      = 30,
  parameter logic [7:0]  SRC_ID          = 8'd0,
  parameter logic [7:0]  SNK_ID          = 8'd1,
  parameter int unsigned NUM_REQ         = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  error,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WIDTH-1:0]      writedata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic                  read,
  input  logic                  waitrequest,
  input  logic [WIDTH-1:0]      readdata,
  input  logic                  readdatavalid
`ifdef QSYS_TGEN_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] run_cycles,
  output logic [PERF_CNT_W-1:0] lat_sum
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQ + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IdxW-1:0] NumReqC  = IdxW'(NUM_REQ);
  localparam logic [IdxW-1:0] LastIdxC = IdxW'(NUM_REQ - 1);
  localparam logic [OutW-1:0] MaxOutC  = OutW'(MAX_OUTSTANDING);

  tgen_state_t           state_q, state_d;
  logic [IdxW-1:0]       wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]       rsp_idx_q, rsp_idx_d;
  logic [OutW-1:0]       outstanding_q, outstanding_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [WIDTH-1:0]      writedata_q, writedata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic            start_acc, wr_acc, rd_acc;
  logic            rsp_hit, rsp_unexp, rsp_bad;
  logic [IdxW-1:0] wr_nxt;
  logic [WIDTH-1:0] exp_rsp;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    write_d       = write_q;
    read_d        = read_q;
    address_d     = address_q;
    writedata_d   = writedata_q;
    done_d        = done_q;
    error_d       = error_q;
    err_count_d   = err_count_q;

    start_acc = start && (state_q == StIdle || state_q == StDone);
    wr_acc    = write_q && !waitrequest;
    rd_acc    = read_q && !waitrequest;
    wr_nxt    = wr_idx_q + IdxW'(1);
    exp_rsp   = WIDTH'(tgen_pattern(SRC_ID, SNK_ID, 32'(rsp_idx_q), WIDTH));

    // Responses are only meaningful once a run has started; idle ignores the bus.
    rsp_hit   = (state_q != StIdle) && readdatavalid && (outstanding_q != '0);
    rsp_unexp = (state_q != StIdle) && readdatavalid && (outstanding_q == '0);
    rsp_bad   = rsp_hit && (readdata != exp_rsp);

    rd_idx_d      = rd_idx_q + IdxW'(rd_acc);
    rsp_idx_d     = rsp_idx_q + IdxW'(rsp_hit);
    outstanding_d = outstanding_q + OutW'(rd_acc) - OutW'(rsp_hit);

    if (rsp_bad || rsp_unexp) begin
      error_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_acc) begin
          state_d       = StWr;
          wr_idx_d      = '0;
          rd_idx_d      = '0;
          rsp_idx_d     = '0;
          outstanding_d = '0;
          done_d        = 1'b0;
          error_d       = 1'b0;
          err_count_d   = '0;
          write_d       = 1'b1;
          read_d        = 1'b0;
          address_d     = '0;
          writedata_d   = WIDTH'(tgen_pattern(SRC_ID, SNK_ID, 32'd0, WIDTH));
        end
      end
      StWr: begin
        if (wr_acc) begin
          if (wr_idx_q == LastIdxC) begin
            // Straight into the read phase with no bubble; nothing is outstanding yet.
            state_d   = StRd;
            write_d   = 1'b0;
            read_d    = 1'b1;
            address_d = '0;
          end else begin
            wr_idx_d    = wr_nxt;
            address_d   = ADDR_WIDTH'(wr_nxt);
            writedata_d = WIDTH'(tgen_pattern(SRC_ID, SNK_ID, 32'(wr_nxt), WIDTH));
          end
        end
      end
      StRd: begin
        if (rd_idx_d == NumReqC) begin
          state_d = StDrain;
          read_d  = 1'b0;
        end else begin
          // Look at next-cycle occupancy so read is never high with the window full.
          address_d = ADDR_WIDTH'(rd_idx_d);
          read_d    = (outstanding_d < MaxOutC);
        end
      end
      StDrain: begin
        if (rsp_idx_d == NumReqC) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      rsp_idx_q     <= '0;
      outstanding_q <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      address_q     <= '0;
      writedata_q   <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      rsp_idx_q     <= rsp_idx_d;
      outstanding_q <= outstanding_d;
      write_q       <= write_d;
      read_q        <= read_d;
      address_q     <= address_d;
      writedata_q   <= writedata_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_count_q   <= err_count_d;
    end
  end

  assign done      = done_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign writedata = writedata_q;
  assign address   = address_q;
  assign write     = write_q;
  assign read      = read_q;

`ifdef QSYS_TGEN_PERF_EN
  logic [PERF_CNT_W-1:0] cyc_q, cyc_d;
  logic [PERF_CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic [PERF_CNT_W-1:0] lat_sum_q, lat_sum_d;
  logic [PERF_CNT_W-1:0] ts_head, rsp_lat;
  logic [PERF_CNT_W:0]   lat_acc;

  // Free-running timebase; latencies are differences so wrap-around is harmless.
  qsys_tgen_ts_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .DW   (PERF_CNT_W)
  ) u_ts_fifo (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (start_acc),
    .push_i(rd_acc),
    .data_i(cyc_q),
    .pop_i (rsp_hit),
    .head_o(ts_head)
  );

  always_comb begin
    cyc_d        = cyc_q + PERF_CNT_W'(1);
    run_cycles_d = run_cycles_q;
    lat_sum_d    = lat_sum_q;
    rsp_lat      = cyc_q - ts_head;
    lat_acc      = {1'b0, lat_sum_q} + {1'b0, rsp_lat};
    if (start_acc) begin
      // The first cycle after start counts as one.
      run_cycles_d = PERF_CNT_W'(1);
      lat_sum_d    = '0;
    end else begin
      if ((state_q == StWr || state_q == StRd || state_q == StDrain) && run_cycles_q != '1) begin
        run_cycles_d = run_cycles_q + PERF_CNT_W'(1);
      end
      if (rsp_hit) lat_sum_d = lat_acc[PERF_CNT_W] ? '1 : lat_acc[PERF_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q        <= '0;
      run_cycles_q <= '0;
      lat_sum_q    <= '0;
    end else begin
      cyc_q        <= cyc_d;
      run_cycles_q <= run_cycles_d;
      lat_sum_q    <= lat_sum_d;
    end
  end

  assign run_cycles = run_cycles_q;
  assign lat_sum    = lat_sum_q;
`endif

endmodule

// File: tb/tb_qsys_master_tgen.sv
module tb_qsys_master_tgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        done, error, write, read;
  logic [15:0] err_count;
  logic [31:0] writedata;
  logic [29:0] address;
`ifdef QSYS_TGEN_PERF_EN
  logic [31:0] run_cycles, lat_sum;
`endif

  qsys_master_tgen #(
    .WIDTH          (32),
    .ADDR_WIDTH     (30),
    .SRC_ID         (8'd0),
    .SNK_ID         (8'd1),
    .NUM_REQ        (16),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done         (done),
    .error        (error),
    .err_count    (err_count),
    .writedata    (writedata),
    .address      (address),
    .write        (write),
    .read         (read),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
`ifdef QSYS_TGEN_PERF_EN
    ,
    .run_cycles   (run_cycles),
    .lat_sum      (lat_sum)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model configuration and run statistics.
  int lat_cfg = 1;
  bit stall_en, flip_en, inject_en, hold_rd_en;
  int wr_n, rd_n, rsp_n, last_rsp_cyc, wr_stall_cnt, rd_stall_cnt;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t        pend_q[$];
  logic [61:0] exp_wr_q[$];
  logic [29:0] exp_rd_q[$];
  logic [31:0] mem [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Avalon slave: decides waitrequest and responses mid-cycle, records accepts.
  initial begin
    rsp_t        rsp;
    bit          prev_wr_stall, prev_rd_stall;
    logic [29:0] prev_addr;
    logic [31:0] prev_wdata;
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    readdata      = '0;
    prev_wr_stall = 1'b0;
    prev_rd_stall = 1'b0;
    prev_addr     = '0;
    prev_wdata    = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        pend_q.delete();
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        prev_wr_stall = 1'b0;
        prev_rd_stall = 1'b0;
        continue;
      end
      if (write || read) check("wr_rd_exclusive", 64'(write & read), 64'd0);
      if (prev_wr_stall) check("wr_hold", {write, address, writedata}, {1'b1, prev_addr, prev_wdata});
      if (prev_rd_stall) check("rd_hold", {read, address}, {1'b1, prev_addr});
      if (read) check("rd_window", 64'((rd_n - rsp_n) < 4), 64'd1);

      waitrequest = 1'b0;
      if (write && stall_en && wr_n == 5 && wr_stall_cnt < 3) begin
        waitrequest = 1'b1;
        wr_stall_cnt++;
      end
      if (read && stall_en && rd_n == 2 && rd_stall_cnt < 3) begin
        waitrequest = 1'b1;
        rd_stall_cnt++;
      end
      if (read && hold_rd_en && rd_n >= 2) waitrequest = 1'b1;

      readdatavalid = 1'b0;
      readdata      = '0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        rsp      = pend_q.pop_front();
        readdata = rsp.data;
        if (flip_en && (rsp_n == 3 || rsp_n == 7)) readdata[0] = ~readdata[0];
        readdatavalid = 1'b1;
        rsp_n++;
        last_rsp_cyc = cyc;
      end else if (inject_en && write && wr_n == 3) begin
        readdatavalid = 1'b1;
        readdata      = 32'hdead_beef;
        inject_en     = 1'b0;
      end

      if (write && !waitrequest) begin
        mem[address[3:0]] = writedata;
        check("wr_sb_nonempty", 64'(exp_wr_q.size() != 0), 64'd1);
        if (exp_wr_q.size() != 0) check("wr_addr_data", {address, writedata}, exp_wr_q.pop_front());
        wr_n++;
      end
      if (read && !waitrequest) begin
        check("rd_sb_nonempty", 64'(exp_rd_q.size() != 0), 64'd1);
        if (exp_rd_q.size() != 0) check("rd_addr", address, exp_rd_q.pop_front());
        pend_q.push_back('{data: mem[address[3:0]], due: cyc + lat_cfg});
        rd_n++;
      end
      prev_wr_stall = write && waitrequest;
      prev_rd_stall = read && waitrequest;
      prev_addr     = address;
      prev_wdata    = writedata;
    end
  end

  task automatic setup(input int lat, input bit st, input bit fl, input bit inj, input bit hold);
    lat_cfg      = lat;
    stall_en     = st;
    flip_en      = fl;
    inject_en    = inj;
    hold_rd_en   = hold;
    wr_n         = 0;
    rd_n         = 0;
    rsp_n        = 0;
    wr_stall_cnt = 0;
    rd_stall_cnt = 0;
    last_rsp_cyc = -100;
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_wr_q.push_back({30'(i), 8'h00, 8'h01, 16'(i)});
      exp_rd_q.push_back(30'(i));
    end
  endtask

  task automatic run(input int lat, input bit st, input bit fl, input bit inj, input bit mid,
                     input logic ex_err, input int ex_cnt, input bit chk_lat);
    int start_cyc, done_cyc;
    bit seen, pulsed;
    setup(lat, st, fl, inj, 1'b0);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("done_cleared", 64'(done), 64'd0);
    check("error_cleared", 64'(error), 64'd0);
    seen     = 1'b0;
    pulsed   = 1'b0;
    done_cyc = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (mid && !pulsed && wr_n >= 8) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    if (seen) check("done_latency", 64'(done_cyc), 64'(last_rsp_cyc + 1));
    check("error", 64'(error), 64'(ex_err));
    check("err_count", 64'(err_count), 64'(ex_cnt));
    check("write_total", 64'(wr_n), 64'd16);
    check("read_total", 64'(rd_n), 64'd16);
    check("rsp_total", 64'(rsp_n), 64'd16);
`ifdef QSYS_TGEN_PERF_EN
    if (seen) check("run_cycles", 64'(run_cycles), 64'(done_cyc - start_cyc));
    if (chk_lat) check("lat_sum", 64'(lat_sum), 64'd160);
`else
    if (chk_lat && seen) check("start_before_done", 64'(done_cyc > start_cyc), 64'd1);
`endif
  endtask

  initial begin
    bit got;
    start = 1'b0;
    rst   = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_write", 64'(write), 64'd0);
    check("rst_read", 64'(read), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_payload", {address, writedata}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // zero-wait baseline
    run(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // stalls on write 5 and read 2
    run(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);  // long latency, full read window
    run(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);   // two corrupted responses
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0);   // stray response + ignored start

    // Abort a run while reads are in flight.
    setup(10, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (rd_n == 2) got = 1'b1;
    end
    check("reached_rd", 64'(got), 64'd1);
    repeat (2) @(negedge clk);
    check("rd_pending_before_rst", 64'(read), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_write", 64'(write), 64'd0);
    check("abort_read", 64'(read), 64'd0);
    check("abort_status", {done, error, err_count}, 64'd0);
    check("abort_payload", {address, writedata}, 64'd0);
    repeat (3) @(negedge clk);
    rst        = 1'b0;
    hold_rd_en = 1'b0;
    repeat (15) @(negedge clk);
    check("idle_after_abort", {write, read, done, error}, 64'd0);

    run(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);  // clean run after abort

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
